// File: rtl/bram_req_adapter.sv
// bram_req_adapter: valid/ready front end for a read-first block RAM, tracking read latency and
// returning one response per request through a credit-sized response FIFO.
module bram_req_adapter #(
  parameter int    RAM_WIDTH       = 32,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  localparam int   AW              = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RAM_WIDTH-1:0] resp_rdata,
  output logic [AW-1:0]        bram_addra,
  output logic [RAM_WIDTH-1:0] bram_dina,
  output logic                 bram_wea,
  output logic                 bram_ena,
  output logic                 bram_regcea,
  output logic                 bram_rsta,
  input  logic [RAM_WIDTH-1:0] bram_douta
);
  localparam int LAT = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam int BD  = LAT + 2;
  localparam int PW  = $clog2(BD);
  localparam int OW  = $clog2(BD + 1);
  logic [LAT-1:0]       vsr;
  logic [PW-1:0]        wp, rp;
  logic [OW-1:0]        occ, cnt;
  logic [RAM_WIDTH-1:0] mem [BD];
  logic                 req_fire, resp_fire, push;
  always_comb begin
    req_ready   = !rsta && (occ < OW'(BD));
    req_fire    = req_valid && req_ready;
    resp_valid  = cnt != '0;
    resp_fire   = resp_valid && resp_ready;
    push        = vsr[LAT-1];
    resp_rdata  = mem[rp];
    bram_ena    = req_fire;
    bram_wea    = req_fire && req_write;
    bram_addra  = req_addr;
    bram_dina   = req_wdata;
    bram_regcea = 1'b1;
    bram_rsta   = rsta;
  end
  // occ counts issued-but-unpopped responses, so the FIFO always has room for every push
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      vsr <= '0;
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      cnt <= '0;
    end else begin
      vsr <= LAT'({vsr, req_fire});
      occ <= occ + OW'(req_fire) - OW'(resp_fire);
      cnt <= cnt + OW'(push) - OW'(resp_fire);
      if (push) wp <= (wp == PW'(BD - 1)) ? '0 : wp + PW'(1);
      if (resp_fire) rp <= (rp == PW'(BD - 1)) ? '0 : rp + PW'(1);
    end
  end
  always_ff @(posedge clka) begin
    if (push) mem[wp] <= bram_douta;
  end
endmodule
